isr_entry_scheduler: RTL
========================

// Module: isr_entry_scheduler
// PURPOSE
//  Schedules two interrupt requesters onto the CPU irq line so that TCB ISR entry stays atomic-compatible.
//  Defers requests while PC is inside SMEM and arbitrates round-robin between sources.
//  Checks that the CPU enters the ISR base matching the granted source, and flags a violation otherwise.
//  Sits beside the PC-atomicity monitor; violation is OR-ed into the system reset request.
// PARAMETERS
//  SMEM_BASE      16'hE000  first SMEM address
//  SMEM_SIZE      16'h1000  SMEM size in bytes; last valid PC = SMEM_BASE+SMEM_SIZE-2
//  ISR1_BASE      16'hDC00  entry vector of source 0 ISR
//  ISR2_BASE      16'hDE00  entry vector of source 1 ISR
//  ISR_SIZE       16'h0200  ISR region size in bytes; ISRn region = [ISRn_BASE, ISRn_BASE+ISR_SIZE-2]
//  GRANT_TIMEOUT  8'd16     cycles allowed from irq_out assertion to the matching ISR entry
//  RESET_HANDLER  16'hFFFE  PC value that clears FAULT
// PORTS
//  clk        in   1   system clock, all state on rising edge
//  reset_n    in   1   asynchronous active-low reset
//  pc         in   16  current CPU program counter
//  irq_req    in   2   level interrupt requests, bit0->ISR1, bit1->ISR2
//  irq_out    out  1   interrupt line to CPU
//  grant_id   out  2   one-hot source currently granted/in service, 0 when none
//  req_ack    out  2   one-cycle pulse to the source whose ISR was entered
//  busy       out  1   1 in DEFER/GRANT/SERVICE
//  violation  out  1   1 in FAULT (sticky until RESET_HANDLER)
// BEHAVIOUR
//  Reset: state=IDLE, pend=0, rr_last=1 (source 0 favoured), timer=0, all outputs 0. Outputs are registered.
//  in_smem = SMEM_BASE <= pc <= SMEM_BASE+SMEM_SIZE-2. in_isrN = pc within the ISRN region.
//  Pending: pend[i] is set on a rising edge of irq_req[i] and cleared when req_ack[i] fires.
//   If set and clear coincide for the same i, set wins and a new request is kept.
//  Arbitration: if both pend bits are set, pick the source != rr_last. rr_last updates on req_ack.
//  States:
//   IDLE:    pend!=0 & in_smem -> DEFER; pend!=0 & !in_smem -> GRANT (latch winner, timer=GRANT_TIMEOUT).
//   DEFER:   hold irq_out=0 while in_smem; on first cycle !in_smem -> GRANT (arbitrate then).
//   GRANT:   irq_out=1, grant_id=winner, timer decrements each cycle.
//            pc==winner base -> SERVICE, req_ack[winner]=1 for exactly one cycle, irq_out->0.
//            pc==other ISR base, or pc in_smem -> FAULT.
//            timer reaches 0 without entry -> FAULT.
//   SERVICE: irq_out=0, grant_id held. Stay while pc in own ISR region.
//            pc==other ISR base (nesting) -> FAULT.
//            pc elsewhere -> IDLE, grant_id=0. Re-arbitrate the next cycle, so at least 1 idle cycle between services.
//   FAULT:   violation=1, irq_out=0, grant_id=0.
//            pc==RESET_HANDLER -> IDLE; clear pend, reset rr_last, violation->0 the following cycle.
//  Latency: request edge to irq_out=1 is 2 cycles when !in_smem (pend register, then GRANT register).
//  Priority within one cycle: FAULT conditions > entry match > timeout decrement.
//  irq_req edges are still captured into pend in every state except FAULT.
//  reset_n low mid-operation: immediate return to reset values, pending requests lost.
// TESTING
//  1. irq_req=01 with pc=16'hC000 -> irq_out=1 two cycles later, grant_id=01; pc=16'hDC00 -> req_ack=01 for 1 cycle, irq_out=0.
//  2. pc=16'hE010, pulse irq_req[1] -> busy=1, irq_out stays 0; pc=16'hEFFE then 16'hC100 -> irq_out=1 the next cycle, grant_id=10.
//  3. Both irq_req bits rise together from reset -> source 0 served first (req_ack=01), then source 1 (req_ack=10) after exit from ISR1.
//  4. Grant source 0, then drive pc=16'hDE00 -> violation=1 next cycle; pc=16'hFFFE -> violation=0, state IDLE, pend=0.
//  5. Grant held with pc=16'hC000 for 16 cycles -> violation=1 on timeout; irq_out=0.
//  6. In SERVICE of ISR1 (pc=16'hDC10), assert reset_n=0 -> all outputs 0 asynchronously; after release, irq_req still high with no new edge -> no grant.

Source files
------------

// File: rtl/isr_entry_scheduler.sv
// Interrupt entry scheduler: defers requests while the PC is inside SMEM and round-robins two sources onto the CPU irq line.
// It also checks that the CPU enters the ISR of the granted source, and latches a sticky violation otherwise.
module isr_entry_scheduler #(
  parameter logic [15:0] SMEM_BASE     = 16'hE000,
  parameter logic [15:0] SMEM_SIZE     = 16'h1000,
  parameter logic [15:0] ISR1_BASE     = 16'hDC00,
  parameter logic [15:0] ISR2_BASE     = 16'hDE00,
  parameter logic [15:0] ISR_SIZE      = 16'h0200,
  parameter logic [7:0]  GRANT_TIMEOUT = 8'd16,
  parameter logic [15:0] RESET_HANDLER = 16'hFFFE
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] pc,
  input  logic [1:0]  irq_req,
  output logic        irq_out,
  output logic [1:0]  grant_id,
  output logic [1:0]  req_ack,
  output logic        busy,
  output logic        violation
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DEFER   = 3'd1,
    S_GRANT   = 3'd2,
    S_SERVICE = 3'd3,
    S_FAULT   = 3'd4
  } state_t;

  localparam logic [15:0] SMEM_LAST = SMEM_BASE + SMEM_SIZE - 16'd2;
  localparam logic [15:0] ISR1_LAST = ISR1_BASE + ISR_SIZE - 16'd2;
  localparam logic [15:0] ISR2_LAST = ISR2_BASE + ISR_SIZE - 16'd2;

  // rr_last holds the index of the last served source; when both are pending the other one wins.
  function automatic logic [1:0] arbitrate(input logic [1:0] pend, input logic rr_last);
    logic [1:0] win;
    case (pend)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = rr_last ? 2'b01 : 2'b10;
      default: win = 2'b00;
    endcase
    return win;
  endfunction

  function automatic logic in_range(input logic [15:0] addr, input logic [15:0] lo, input logic [15:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

  state_t      state_q, state_d;
  logic [1:0]  pend_q, pend_d;
  logic        rr_last_q, rr_last_d;
  logic [7:0]  timer_q, timer_d;
  logic [1:0]  win_q, win_d;
  logic [1:0]  prev_q;
  logic        armed_q;
  logic        irq_out_q, irq_out_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  ack_q, ack_d;
  logic        busy_q, busy_d;
  logic        viol_q, viol_d;

  logic        in_smem_s, own_region_s;
  logic [15:0] own_base_s, other_base_s;
  logic [1:0]  rise_s;
  logic        capture_s, clear_s;

  // A level already high when reset releases is not an edge, hence the armed flag.
  assign rise_s       = armed_q ? (irq_req & ~prev_q) : 2'b00;
  assign in_smem_s    = in_range(pc, SMEM_BASE, SMEM_LAST);
  assign own_base_s   = win_q[1] ? ISR2_BASE : ISR1_BASE;
  assign other_base_s = win_q[1] ? ISR1_BASE : ISR2_BASE;
  assign own_region_s = win_q[1] ? in_range(pc, ISR2_BASE, ISR2_LAST)
                                 : in_range(pc, ISR1_BASE, ISR1_LAST);

  // Next-state, pending and output computation.
  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    timer_d   = timer_q;
    rr_last_d = rr_last_q;
    ack_d     = 2'b00;
    capture_s = 1'b1;
    clear_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pend_q != 2'b00) begin
          if (in_smem_s) begin
            state_d = S_DEFER;
          end else begin
            state_d = S_GRANT;
            win_d   = arbitrate(pend_q, rr_last_q);
            timer_d = GRANT_TIMEOUT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DEFER: begin
        if (!in_smem_s) begin
          state_d = S_GRANT;
          win_d   = arbitrate(pend_q, rr_last_q);
          timer_d = GRANT_TIMEOUT;
        end else begin
          state_d = S_DEFER;
        end
      end
      S_GRANT: begin
        // Fault conditions outrank a matching entry, which outranks the timeout.
        if ((pc == other_base_s) || in_smem_s) begin
          state_d = S_FAULT;
        end else if (pc == own_base_s) begin
          state_d   = S_SERVICE;
          ack_d     = win_q;
          rr_last_d = win_q[1];
        end else if (timer_q <= 8'd1) begin
          state_d = S_FAULT;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      S_SERVICE: begin
        if (pc == other_base_s) begin
          state_d = S_FAULT;
        end else if (own_region_s) begin
          state_d = S_SERVICE;
        end else begin
          state_d = S_IDLE;
          win_d   = 2'b00;
        end
      end
      S_FAULT: begin
        capture_s = 1'b0;
        if (pc == RESET_HANDLER) begin
          state_d   = S_IDLE;
          clear_s   = 1'b1;
          rr_last_d = 1'b1;
          win_d     = 2'b00;
        end else begin
          state_d = S_FAULT;
        end
      end
      default: begin
        state_d = S_IDLE;
        win_d   = 2'b00;
      end
    endcase

    // Set wins over a coinciding acknowledge so a fresh request is never dropped.
    if (clear_s) begin
      pend_d = 2'b00;
    end else begin
      pend_d = (pend_q & ~ack_d) | (capture_s ? rise_s : 2'b00);
    end

    irq_out_d = (state_d == S_GRANT);
    grant_d   = ((state_d == S_GRANT) || (state_d == S_SERVICE)) ? win_d : 2'b00;
    busy_d    = (state_d == S_DEFER) || (state_d == S_GRANT) || (state_d == S_SERVICE);
    viol_d    = (state_d == S_FAULT);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      pend_q    <= 2'b00;
      rr_last_q <= 1'b1;
      timer_q   <= 8'd0;
      win_q     <= 2'b00;
      prev_q    <= 2'b00;
      armed_q   <= 1'b0;
      irq_out_q <= 1'b0;
      grant_q   <= 2'b00;
      ack_q     <= 2'b00;
      busy_q    <= 1'b0;
      viol_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      rr_last_q <= rr_last_d;
      timer_q   <= timer_d;
      win_q     <= win_d;
      prev_q    <= irq_req;
      armed_q   <= 1'b1;
      irq_out_q <= irq_out_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      viol_q    <= viol_d;
    end
  end

  assign irq_out   = irq_out_q;
  assign grant_id  = grant_q;
  assign req_ack   = ack_q;
  assign busy      = busy_q;
  assign violation = viol_q;

endmodule
